// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for the 5-stage pipeline.
// Optional statistics counters are built only when FWD_STATS_EN is defined.
module fwd_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              fwd_b,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] fwd_cnt
);

  localparam int            CW       = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_LAT - 1);
  localparam logic [1:0]    SEL_RF   = 2'b00;
  localparam logic [1:0]    SEL_WB   = 2'b01;
  localparam logic [1:0]    SEL_MEM  = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } tag_t;

  function automatic logic writes(input tag_t t, input logic [REG_AW-1:0] r);
    return t.valid && t.reg_write && (t.rd == r) && (r != '0);
  endfunction

  // The WB-stage tag is not kept: the regfile writes before ID reads, so it never forwards.
  tag_t          ex_q, mem_q, ex_d;
  logic [CW-1:0] cnt_q;
  logic          ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic          hazard, transfer;
  logic [1:0]    sel_a_d, sel_b_d;

  always_comb begin
    ex_hit_a  = writes(ex_q, id_rs);
    ex_hit_b  = id_use_rt && writes(ex_q, id_rt);
    mem_hit_a = writes(mem_q, id_rs);
    mem_hit_b = id_use_rt && writes(mem_q, id_rt);
    hazard    = id_valid && !flush && ex_q.mem_read && (ex_hit_a || ex_hit_b);
    stall     = hazard || (cnt_q != '0);
    transfer  = id_valid && !flush && !stall;
    ex_d      = transfer ? {id_valid, id_rd, id_reg_write, id_mem_read} : '0;
    sel_a_d   = SEL_RF;
    sel_b_d   = SEL_RF;
    if (transfer) begin
      if (ex_hit_a && !ex_q.mem_read) sel_a_d = SEL_MEM;
      else if (mem_hit_a)             sel_a_d = SEL_WB;
      if (ex_hit_b && !ex_q.mem_read) sel_b_d = SEL_MEM;
      else if (mem_hit_b)             sel_b_d = SEL_WB;
    end
  end

  // Down-counter holds the remaining load-latency stall cycles after the first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt_q <= '0;
    else if (flush)         cnt_q <= '0;
    else if (cnt_q != '0)   cnt_q <= cnt_q - CW'(1);
    else if (hazard)        cnt_q <= CNT_LOAD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      sel_a <= SEL_RF;
      sel_b <= SEL_RF;
    end else begin
      mem_q <= ex_q;
      ex_q  <= ex_d;
      sel_a <= sel_a_d;
      sel_b <= sel_b_d;
    end
  end

  assign fwd_b = (sel_b != SEL_RF);

`ifdef FWD_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;
  logic [STAT_W-1:0] stall_cnt_q, fwd_cnt_q;
  logic [1:0]        fwd_inc;
  logic [STAT_W:0]   fwd_sum;

  always_comb begin
    fwd_inc = {1'b0, sel_a_d != SEL_RF} + {1'b0, sel_b_d != SEL_RF};
    fwd_sum = {1'b0, fwd_cnt_q} + {{(STAT_W-1){1'b0}}, fwd_inc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall && (stall_cnt_q != STAT_MAX)) stall_cnt_q <= stall_cnt_q + STAT_W'(1);
      fwd_cnt_q <= fwd_sum[STAT_W] ? STAT_MAX : fwd_sum[STAT_W-1:0];
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: two instances (LOAD_LAT 1 and 3) share stimulus;
// a directed vector table, hand sequences, then random traffic against a reference model.
module tb_fwd_hazard_ctrl;
  localparam int AW   = 5;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_rt, id_reg_write, id_mem_read, flush;
  logic [AW-1:0] id_rs, id_rt, id_rd;

  logic          stall_o [2];
  logic [1:0]    sa_o    [2];
  logic [1:0]    sb_o    [2];
  logic          fb_o    [2];
  logic [SW-1:0] sc_o    [2];
  logic [SW-1:0] fc_o    [2];

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(AW), .LOAD_LAT(1), .STAT_W(SW)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rt(id_use_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .stall(stall_o[0]), .sel_a(sa_o[0]),
    .sel_b(sb_o[0]), .fwd_b(fb_o[0]), .stall_cnt(sc_o[0]), .fwd_cnt(fc_o[0]));

  fwd_hazard_ctrl #(.REG_AW(AW), .LOAD_LAT(3), .STAT_W(SW)) dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rt(id_use_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .stall(stall_o[1]), .sel_a(sa_o[1]),
    .sel_b(sb_o[1]), .fwd_b(fb_o[1]), .stall_cnt(sc_o[1]), .fwd_cnt(fc_o[1]));

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_model = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the two most recent instructions sent to EX, youngest first.
  typedef struct packed { logic v; logic [AW-1:0] rd; logic rw; logic mr; } mtag_t;
  mtag_t recent [2][2];
  int    rem    [2];
  int    m_sa [2], m_sb [2], m_sc [2], m_fc [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic bit mw(input mtag_t t, input logic [AW-1:0] r);
    return t.v && t.rw && (t.rd == r) && (r != 0);
  endfunction

  function automatic bit m_hazard(input int d);
    mtag_t y;
    y = recent[d][0];
    return id_valid && !flush && y.mr && (mw(y, id_rs) || (id_use_rt && mw(y, id_rt)));
  endfunction

  function automatic bit m_stall(input int d);
    return m_hazard(d) || (rem[d] > 0);
  endfunction

  function automatic int m_pick(input int d, input logic [AW-1:0] r);
    if (mw(recent[d][0], r) && !recent[d][0].mr) return 2;
    if (mw(recent[d][1], r)) return 1;
    return 0;
  endfunction

  function automatic int sat(input int x);
    return (x > SMAX) ? SMAX : x;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      recent[d][0] = '0; recent[d][1] = '0;
      rem[d] = 0; m_sa[d] = 0; m_sb[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
    end
  endtask

  task automatic m_edge();
    for (int d = 0; d < 2; d++) begin
      bit hz, st, go;
      hz = m_hazard(d);
      st = m_stall(d);
      go = id_valid && !flush && !st;
      if (st) m_sc[d] = sat(m_sc[d] + 1);
      m_sa[d] = go ? m_pick(d, id_rs) : 0;
      m_sb[d] = (go && id_use_rt) ? m_pick(d, id_rt) : 0;
      m_fc[d] = sat(m_fc[d] + int'(m_sa[d] != 0) + int'(m_sb[d] != 0));
      if (flush)          rem[d] = 0;
      else if (rem[d] > 0) rem[d] = rem[d] - 1;
      else if (hz)        rem[d] = lat_of(d) - 1;
      recent[d][1] = recent[d][0];
      recent[d][0] = go ? mtag_t'({id_valid, id_rd, id_reg_write, id_mem_read}) : mtag_t'('0);
    end
  endtask

  task automatic check_stats();
    for (int d = 0; d < 2; d++) begin
`ifdef FWD_STATS_EN
      check($sformatf("stall_cnt[%0d]", d), int'(sc_o[d]), m_sc[d]);
      check($sformatf("fwd_cnt[%0d]", d), int'(fc_o[d]), m_fc[d]);
`else
      check($sformatf("stall_cnt[%0d]", d), int'(sc_o[d]), 0);
      check($sformatf("fwd_cnt[%0d]", d), int'(fc_o[d]), 0);
`endif
    end
  endtask

  task automatic set_in(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic ut, input logic [AW-1:0] rd, input logic rw,
                        input logic mr, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rt = ut;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic cycle();
    #1;
    if (chk_model)
      for (int d = 0; d < 2; d++) check($sformatf("stall[%0d]", d), int'(stall_o[d]), int'(m_stall(d)));
    @(posedge clk);
    m_edge();
    #1;
    check_stats();
    if (chk_model)
      for (int d = 0; d < 2; d++) begin
        check($sformatf("sel_a[%0d]", d), int'(sa_o[d]), m_sa[d]);
        check($sformatf("sel_b[%0d]", d), int'(sb_o[d]), m_sb[d]);
        check($sformatf("fwd_b[%0d]", d), int'(fb_o[d]), int'(m_sb[d] != 0));
      end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst stall[%0d]", d), int'(stall_o[d]), 0);
      check($sformatf("rst sel_a[%0d]", d), int'(sa_o[d]), 0);
      check($sformatf("rst sel_b[%0d]", d), int'(sb_o[d]), 0);
      check($sformatf("rst fwd_b[%0d]", d), int'(fb_o[d]), 0);
      check($sformatf("rst stall_cnt[%0d]", d), int'(sc_o[d]), 0);
      check($sformatf("rst fwd_cnt[%0d]", d), int'(fc_o[d]), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic v; logic [AW-1:0] rs, rt; logic ut; logic [AW-1:0] rd; logic rw, mr, fl;
    logic st; logic [1:0] sa, sb;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                              input logic ut, input logic [AW-1:0] rd, input logic rw,
                              input logic mr, input logic fl, input logic st,
                              input logic [1:0] sa, input logic [1:0] sb);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.ut = ut; r.rd = rd; r.rw = rw; r.mr = mr; r.fl = fl;
    r.st = st; r.sa = sa; r.sb = sb;
    return r;
  endfunction

  vec_t tbl [20];

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    //              v  rs  rt ut rd rw mr fl  st sa sb
    tbl[0]  = mk(1,  1,  2, 1, 3, 1, 0, 0,  0, 0, 0);  // add r3
    tbl[1]  = mk(1,  3,  3, 1, 4, 1, 0, 0,  0, 2, 2);  // add r4,r3,r3
    tbl[2]  = mk(0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0);
    tbl[3]  = mk(1,  1,  2, 1, 3, 1, 0, 0,  0, 0, 0);  // add r3
    tbl[4]  = mk(0,  0,  0, 0, 0, 0, 0, 0,  0, 0, 0);
    tbl[5]  = mk(1,  3,  2, 1, 5, 1, 0, 0,  0, 1, 0);  // sub r5,r3,r2
    tbl[6]  = mk(1,  1,  0, 0, 2, 1, 1, 0,  0, 0, 0);  // lw r2
    tbl[7]  = mk(1,  2,  1, 1, 4, 1, 0, 0,  1, 0, 0);  // add r4,r2,r1 stalls
    tbl[8]  = mk(1,  2,  1, 1, 4, 1, 0, 0,  0, 1, 0);  // held, load now in MEM
    tbl[9]  = mk(1,  0,  0, 0, 0, 1, 1, 0,  0, 0, 0);  // lw r0
    tbl[10] = mk(1,  0,  0, 1, 6, 1, 0, 0,  0, 0, 0);  // add r6,r0,r0
    tbl[11] = mk(1,  1,  1, 1, 0, 1, 0, 0,  0, 0, 0);  // add r0
    tbl[12] = mk(1,  0,  0, 1, 7, 1, 0, 0,  0, 0, 0);  // add r7,r0,r0
    tbl[13] = mk(1,  1,  1, 1, 9, 1, 0, 0,  0, 0, 0);  // add r9
    tbl[14] = mk(1,  1,  9, 0, 10, 1, 0, 0, 0, 0, 0);  // addi, rt not on B path
    tbl[15] = mk(1,  9, 10, 0, 11, 1, 0, 0, 0, 1, 0);  // addi r11,r9
    tbl[16] = mk(1,  1,  1, 1, 11, 1, 0, 0, 0, 0, 0);  // add r11
    tbl[17] = mk(1, 11, 10, 1, 12, 1, 0, 0, 0, 2, 0);  // younger wins; r10 in WB
    tbl[18] = mk(1, 12,  1, 1, 13, 1, 0, 1, 0, 0, 0);  // flushed
    tbl[19] = mk(1, 13, 12, 1, 14, 1, 0, 0, 0, 0, 1);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].ut, tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].fl);
      #1;
      check($sformatf("tbl%0d stall", i), int'(stall_o[0]), int'(tbl[i].st));
      cycle();
      check($sformatf("tbl%0d sel_a", i), int'(sa_o[0]), int'(tbl[i].sa));
      check($sformatf("tbl%0d sel_b", i), int'(sb_o[0]), int'(tbl[i].sb));
      check($sformatf("tbl%0d fwd_b", i), int'(fb_o[0]), int'(tbl[i].sb != 2'b00));
    end

    // LOAD_LAT=3: three consecutive stall cycles, then transfer with no forwarding.
    do_reset();
    set_in(1, 1, 0, 0, 2, 1, 1, 0);
    cycle();
    set_in(1, 2, 1, 1, 4, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("lat3 stall k=%0d", k), int'(stall_o[1]), int'(k < 3));
      cycle();
    end
    check("lat3 sel_a", int'(sa_o[1]), 0);

    // Flush on the hazard cycle itself beats the stall.
    do_reset();
    set_in(1, 1, 0, 0, 2, 1, 1, 0);
    cycle();
    set_in(1, 2, 1, 1, 4, 1, 0, 1);
    #1;
    check("flush@hazard stall", int'(stall_o[0]), 0);
    cycle();
    flush = 1'b0;
    #1;
    check("after flush stall", int'(stall_o[0]), 0);
    cycle();
    check("after flush sel_a", int'(sa_o[0]), 1);

    // Flush in the middle of a LOAD_LAT=3 stall clears the remaining cycles.
    do_reset();
    set_in(1, 1, 0, 0, 2, 1, 1, 0);
    cycle();
    set_in(1, 2, 1, 1, 4, 1, 0, 0);
    #1;
    check("mid-stall pre stall", int'(stall_o[1]), 1);
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    #1;
    check("mid-stall flush stall", int'(stall_o[1]), 0);
    cycle();
    check("mid-stall flush sel_a", int'(sa_o[1]), 0);

    // Asynchronous reset while dut3 is stalling and dut1 holds a forward select.
    do_reset();
    set_in(1, 1, 0, 0, 2, 1, 1, 0);
    cycle();
    set_in(1, 2, 1, 1, 4, 1, 0, 0);
    cycle();
    cycle();
    check("pre-rst sel_a", int'(sa_o[0]), 1);
    check("pre-rst stall", int'(stall_o[1]), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst stall", int'(stall_o[1]), 0);
    check("async rst sel_a", int'(sa_o[0]), 0);
    check("async rst fwd_b", int'(fb_o[0]), 0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two load-use stalls and three forwarded operands on dut1.
    do_reset();
    set_in(1, 1, 1, 1, 3, 1, 0, 0); cycle();
    set_in(1, 3, 1, 1, 4, 1, 0, 0); cycle();
    set_in(1, 0, 0, 0, 2, 1, 1, 0); cycle();
    set_in(1, 2, 0, 1, 5, 1, 0, 0); cycle(); cycle();
    set_in(1, 0, 0, 0, 6, 1, 1, 0); cycle();
    set_in(1, 6, 0, 0, 7, 1, 0, 0); cycle(); cycle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle();
`ifdef FWD_STATS_EN
    check("stats stall_cnt", int'(sc_o[0]), 2);
    check("stats fwd_cnt", int'(fc_o[0]), 3);
`else
    check("stats stall_cnt", int'(sc_o[0]), 0);
    check("stats fwd_cnt", int'(fc_o[0]), 0);
`endif

    // Random traffic on a small register set; ID is usually held while dut1 stalls.
    do_reset();
    chk_model = 1;
    for (int n = 0; n < 3000; n++) begin
      if (!(m_stall(0) && ($urandom_range(0, 3) != 0)))
        set_in($urandom_range(0, 9) != 0, AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      cycle();
      if ((n % 700) == 699) do_reset();
    end
    chk_model = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
